// File: rtl/ca_pkg.sv
// Shared types and defaults for the cellular-automaton ring engine.
package ca_pkg;

   localparam int unsigned N_CELLS_DEF = 8;
   localparam int unsigned GEN_W_DEF   = 16;

   localparam logic EDGE_WRAP = 1'b0;
   localparam logic EDGE_ZERO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVAL   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/ca_rule_lut.sv
// Wolfram rule lookup: the neighbourhood {L,C,R} selects one bit of the rule byte.
module ca_rule_lut (
   input  logic [7:0] rule,
   input  logic [2:0] nbhd,
   output logic       next_state
);

   assign next_state = rule[nbhd];

endmodule

// File: rtl/ca_ring_engine.sv
// Ring of 1-bit cells advanced one generation per step request, one cell per cycle,
// double-buffered so the visible generation only changes on commit.
module ca_ring_engine
   import ca_pkg::*;
#(
   parameter int unsigned N_CELLS = N_CELLS_DEF,
   parameter int unsigned GEN_W   = GEN_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   input  logic [N_CELLS-1:0] load_data,
   output logic               load_ready,
   input  logic [7:0]         rule,
   input  logic               edge_mode,
   input  logic               step_req,
   output logic               busy,
   output logic               step_done,
   output logic [N_CELLS-1:0] cells,
   output logic [GEN_W-1:0]   gen_count
);

   localparam int unsigned      IDX_W    = $clog2(N_CELLS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CELLS - 1);

   state_t             state;
   logic [N_CELLS-1:0] next_buf;
   logic [IDX_W-1:0]   idx;
   logic [7:0]         rule_sh;
   logic               edge_sh;
   logic               nb_l;
   logic               nb_c;
   logic               nb_r;
   logic               lut_out;

   // Gather the neighbourhood of the cell under evaluation; edges wrap or read zero.
   always_comb begin
      nb_l = 1'b0;
      nb_r = 1'b0;
      nb_c = cells[idx];
      if (idx == IDX_LAST) begin
         if (edge_sh == EDGE_WRAP) nb_l = cells[0];
      end else begin
         nb_l = cells[idx + IDX_W'(1)];
      end
      if (idx == '0) begin
         if (edge_sh == EDGE_WRAP) nb_r = cells[N_CELLS-1];
      end else begin
         nb_r = cells[idx - IDX_W'(1)];
      end
   end

   ca_rule_lut u_lut (
      .rule       (rule_sh),
      .nbhd       ({nb_l, nb_c, nb_r}),
      .next_state (lut_out)
   );

   // Control FSM with registered status outputs; step_done is high for the COMMIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cells      <= '0;
         next_buf   <= '0;
         gen_count  <= '0;
         idx        <= '0;
         rule_sh    <= '0;
         edge_sh    <= EDGE_WRAP;
         step_done  <= 1'b0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         step_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (load_valid) begin
                  cells     <= load_data;
                  gen_count <= '0;
               end else if (step_req) begin
                  rule_sh    <= rule;
                  edge_sh    <= edge_mode;
                  idx        <= '0;
                  state      <= ST_EVAL;
                  busy       <= 1'b1;
                  load_ready <= 1'b0;
               end
            end
            ST_EVAL: begin
               next_buf[idx] <= lut_out;
               if (idx == IDX_LAST) begin
                  state     <= ST_COMMIT;
                  step_done <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_COMMIT: begin
               cells      <= next_buf;
               gen_count  <= gen_count + GEN_W'(1);
               state      <= ST_IDLE;
               busy       <= 1'b0;
               load_ready <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ca_ring_engine.sv
// Randomized self-checking bench for ca_ring_engine against an array-based ring model.
module tb_ca_ring_engine;

   localparam int unsigned N  = 8;
   localparam int unsigned GW = 4;

   logic          clk;
   logic          rst;
   logic          load_valid;
   logic [N-1:0]  load_data;
   logic          load_ready;
   logic [7:0]    rule;
   logic          edge_mode;
   logic          step_req;
   logic          busy;
   logic          step_done;
   logic [N-1:0]  cells;
   logic [GW-1:0] gen_count;

   int n_tests;
   int n_fail;
   int n_pulses;

   logic [N-1:0] model_cells;
   int           model_gen;

   ca_ring_engine #(.N_CELLS(N), .GEN_W(GW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .rule       (rule),
      .edge_mode  (edge_mode),
      .step_req   (step_req),
      .busy       (busy),
      .step_done  (step_done),
      .cells      (cells),
      .gen_count  (gen_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Next generation straight from the rule definition, using modular neighbour positions.
   function automatic logic [N-1:0] model_step(input logic [N-1:0] c, input logic [7:0] r,
                                               input logic zero_edges);
      logic [N-1:0] nxt;
      int l, cc, rr, p;
      for (int i = 0; i < int'(N); i++) begin
         l  = int'(c[(i + 1) % N]);
         rr = int'(c[(i + N - 1) % N]);
         cc = int'(c[i]);
         if (zero_edges && i == int'(N) - 1) l = 0;
         if (zero_edges && i == 0) rr = 0;
         p = 4 * l + 2 * cc + rr;
         nxt[i] = r[p];
      end
      return nxt;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      step_req = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      model_cells = '0;
      model_gen = 0;
   endtask

   task automatic do_load(input logic [N-1:0] d);
      load_valid = 1'b1;
      load_data = d;
      tick();
      load_valid = 1'b0;
      model_cells = d;
      model_gen = 0;
      check("load_cells", 64'(cells), 64'(d));
      check("load_gen", 64'(gen_count), 64'(0));
   endtask

   // One step; optionally toggles load/step/rule/edge inputs while busy to show they are ignored.
   task automatic do_step(input logic [7:0] r, input logic m, input bit junk);
      int cyc;
      bit seen;
      rule = r;
      edge_mode = m;
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      cyc = 1;
      seen = 1'b0;
      model_cells = model_step(model_cells, r, m);
      model_gen++;
      check("busy_after_accept", 64'(busy), 64'(1));
      while (!seen && cyc < 40) begin
         if (step_done) begin
            seen = 1'b1;
         end else begin
            if (junk) begin
               load_valid = 1'($urandom % 2);
               load_data = N'($urandom);
               step_req = 1'($urandom % 2);
               rule = 8'($urandom);
               edge_mode = 1'($urandom % 2);
            end
            tick();
            cyc++;
         end
      end
      if (!seen) begin
         load_valid = 1'b0;
         step_req = 1'b0;
         check("step_done_timeout", 64'(0), 64'(1));
      end else begin
         n_pulses++;
         check("step_latency", 64'(cyc), 64'(N + 1));
         check("busy_in_commit", 64'(busy), 64'(1));
         check("ready_in_commit", 64'(load_ready), 64'(0));
         load_valid = 1'b0;
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         check("step_done_one_cycle", 64'(step_done), 64'(0));
         check("idle_after_commit", 64'(busy), 64'(0));
         check("ready_after_commit", 64'(load_ready), 64'(1));
         check("step_cells", 64'(cells), 64'(model_cells));
         check("step_gen", 64'(gen_count), 64'(model_gen % (1 << GW)));
      end
   endtask

   initial begin
      int pulses_before;
      int highs;
      n_tests = 0;
      n_fail = 0;
      n_pulses = 0;
      rst = 1'b0;
      load_valid = 1'b0;
      load_data = '0;
      rule = '0;
      edge_mode = 1'b0;
      step_req = 1'b0;

      do_reset();
      check("rst_cells", 64'(cells), 64'(0));
      check("rst_gen", 64'(gen_count), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ready", 64'(load_ready), 64'(1));
      check("rst_step_done", 64'(step_done), 64'(0));

      // Single glider under rule 90, wrap.
      do_load(8'b0001_0000);
      do_step(8'd90, 1'b0, 1'b0);
      check("r90_wrap_glider", 64'(cells), 64'(8'b0010_1000));
      check("r90_wrap_gen", 64'(gen_count), 64'(1));

      // Edge cell in wrap versus fixed-zero mode.
      do_load(8'b0000_0001);
      do_step(8'd90, 1'b0, 1'b0);
      check("r90_wrap_edge", 64'(cells), 64'(8'b1000_0010));
      do_load(8'b0000_0001);
      do_step(8'd90, 1'b1, 1'b0);
      check("r90_zero_edge", 64'(cells), 64'(8'b0000_0010));

      // Identity rule, back-to-back steps with noisy inputs while busy.
      do_load(8'hA5);
      pulses_before = n_pulses;
      repeat (3) do_step(8'd204, 1'($urandom % 2), 1'b1);
      check("r204_cells", 64'(cells), 64'(8'hA5));
      check("r204_gen", 64'(gen_count), 64'(3));
      check("r204_pulses", 64'(n_pulses - pulses_before), 64'(3));

      // Load and step together in idle: load wins, no step starts.
      load_valid = 1'b1;
      step_req = 1'b1;
      load_data = 8'h3C;
      tick();
      load_valid = 1'b0;
      step_req = 1'b0;
      model_cells = 8'h3C;
      model_gen = 0;
      check("both_cells", 64'(cells), 64'(8'h3C));
      check("both_busy", 64'(busy), 64'(0));
      highs = 0;
      for (int k = 0; k < 12; k++) begin
         if (step_done || busy) highs++;
         tick();
      end
      check("both_no_step", 64'(highs), 64'(0));
      do_step(8'd30, 1'b0, 1'b1);

      // Reset in the middle of evaluation aborts the step.
      do_load(8'h5A);
      rule = 8'd110;
      edge_mode = 1'b0;
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_cells = '0;
      model_gen = 0;
      check("abort_cells", 64'(cells), 64'(0));
      check("abort_gen", 64'(gen_count), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_ready", 64'(load_ready), 64'(1));
      highs = 0;
      for (int k = 0; k < 12; k++) begin
         if (step_done) highs++;
         tick();
      end
      check("abort_no_pulse", 64'(highs), 64'(0));

      // Generation counter wraps after 16 commits.
      do_load(8'h01);
      for (int k = 0; k < 16; k++) begin
         do_step(8'($urandom), 1'($urandom % 2), 1'b0);
         if (k == 14) check("gen_at_15", 64'(gen_count), 64'(15));
      end
      check("gen_wrap_0", 64'(gen_count), 64'(0));

      // Random loads and steps.
      for (int k = 0; k < 30; k++) begin
         if ($urandom % 3 == 0) do_load(N'($urandom));
         do_step(8'($urandom), 1'($urandom % 2), 1'($urandom % 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ca_ring_engine.md
CA_RING_ENGINE -- requirements
Module: ca_ring_engine

Interface
REQ-001 Parameter N_CELLS, default 8, number of 1-bit cells in the ring; legal range 3..64.
REQ-002 Parameter GEN_W, default 16, width of the generation counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_valid  input  1  request to load a new pattern into the cells.
REQ-006 load_data  input  N_CELLS  pattern to load; bit i is cell i.
REQ-007 load_ready  output  1  high when a load can be accepted.
REQ-008 rule  input  8  Wolfram-style rule table, indexed by neighbourhood.
REQ-009 edge_mode  input  1  boundary mode: 0 = ring wrap, 1 = fixed-zero edges.
REQ-010 step_req  input  1  request to compute one generation.
REQ-011 busy  output  1  high while a generation is being computed.
REQ-012 step_done  output  1  one-cycle pulse when a new generation is committed.
REQ-013 cells  output  N_CELLS  current committed generation.
REQ-014 gen_count  output  GEN_W  number of generations committed since the last load or reset.

Function
REQ-015 FSM states: IDLE, EVAL, COMMIT.
REQ-016 IDLE: load_ready=1, busy=0.
REQ-017 IDLE with load_valid=1: cells <= load_data, gen_count <= 0, next cycle still IDLE.
REQ-018 IDLE with step_req=1 and load_valid=0: capture rule and edge_mode into shadow registers, clear index to 0, go to EVAL.
REQ-019 IDLE with both load_valid and step_req high: load wins; step_req is dropped and not queued.
REQ-020 EVAL: one cell per cycle, index i from 0 to N_CELLS-1.
REQ-021 Neighbourhood of cell i is p = {L,C,R}, with L = cells[i+1], C = cells[i], R = cells[i-1]; the next value of cell i is rule_shadow[p].
REQ-022 Wrap mode: cell i+1 for i = N_CELLS-1 is cell 0, and cell i-1 for i = 0 is cell N_CELLS-1.
REQ-023 Fixed-zero mode: out-of-range neighbours read as 0.
REQ-024 Results go to a separate next buffer; cells stays unchanged during EVAL (double buffering).
REQ-025 After i = N_CELLS-1 is evaluated, go to COMMIT.
REQ-026 COMMIT: cells <= next buffer, gen_count <= gen_count+1 (wraps modulo 2^GEN_W), step_done=1 for that cycle, then go to IDLE.
REQ-027 Latency from the accepting step_req edge to the step_done pulse is exactly N_CELLS+1 cycles.
REQ-028 busy=1 in EVAL and COMMIT; load_ready=0 in those states.
REQ-029 load_valid and step_req while busy are ignored, with no effect and no queueing.
REQ-030 Changes to rule or edge_mode while busy do not affect the generation in flight.
REQ-031 A step_req sampled in the same cycle that step_done is high is ignored; the state is COMMIT at that point.

Reset
REQ-032 While rst=1 at a clock edge: state <= IDLE, cells <= 0, next buffer <= 0, gen_count <= 0, index <= 0, shadow rule <= 0, step_done <= 0.
REQ-033 rst asserted mid-EVAL or mid-COMMIT aborts the step; no partial commit and no step_done pulse.
REQ-034 rst has priority over load_valid and step_req.

Structure
REQ-035 Shared package ca_pkg holds: the FSM state enum; the N_CELLS and GEN_W defaults; the edge-mode constants EDGE_WRAP=0 and EDGE_ZERO=1.
REQ-036 Sub-module ca_rule_lut is combinational: 8-bit rule plus 3-bit neighbourhood in, 1-bit next state out; it is instantiated once.
REQ-037 The index counter is $clog2(N_CELLS) bits wide.

Verification
REQ-038 N=8, load 8'b0001_0000, rule 90, wrap, step -> cells=8'b0010_1000, gen_count=1, step_done exactly 9 cycles after accept.
REQ-039 N=8, load 8'b0000_0001, rule 90: in wrap mode step -> 8'b1000_0010; reload and step in zero mode -> 8'b0000_0010.
REQ-040 Rule 204 (identity), load 8'hA5, 3 back-to-back steps -> cells stays 8'hA5, gen_count=3, three step_done pulses.
REQ-041 load_valid and step_req together in IDLE -> load applied, busy stays 0, no step_done; load_valid mid-EVAL -> ignored, result unchanged.
REQ-042 rst at EVAL index 4 -> next cycle cells=0, gen_count=0, IDLE, no step_done pulse.
REQ-043 GEN_W=4, run 16 steps -> gen_count wraps from 15 to 0.
